// File: rtl/ubio_pkg.sv
// Shared definitions for the uBio core: cycle state codes, run states,
// default datapath widths and opcode constants.
package ubio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_WBACK   = 3'd4
    } cycle_state_t;

    typedef enum logic {
        RUN_HALTED = 1'b0,
        RUN_ACTIVE = 1'b1
    } run_state_t;

    localparam int AW_DEF  = 8;
    localparam int IW_DEF  = 16;
    localparam int OPW_DEF = 4;

    localparam logic [OPW_DEF-1:0] OP_NOP  = 4'h0;
    localparam logic [OPW_DEF-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with next-PC selection: branch target, increment
// (modulo 2^AW) or hold.
module fetch_pc
    import ubio_pkg::*;
#(
    parameter int              AW       = AW_DEF,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;

    // A load takes priority; the caller never asserts both together.
    always_comb begin
        w_pc_next = r_pc;
        if (load) begin
            w_pc_next = target;
        end else if (inc) begin
            w_pc_next = r_pc + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// uBio instruction-fetch / PC stage: run FSM driving the stop flag S, IR with
// DECODE bypass, PC ownership. Optional retired counter: FETCH_INSTR_COUNT_EN.
module fetch_unit
    import ubio_pkg::*;
#(
    parameter int              AW       = AW_DEF,
    parameter int              IW       = IW_DEF,
    parameter int              OPW      = OPW_DEF,
    parameter logic [OPW-1:0]  HALT_OP  = OP_HALT,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    state,
    input  logic          start,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] ir,
    output logic          ir_valid,
    output logic [AW-1:0] pc,
    output logic          S
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [31:0]   retired
`endif
);

    run_state_t    r_run_state;
    logic [IW-1:0] r_ir_q;
    logic [AW-1:0] w_pc;
    logic          w_in_decode;
    logic          w_in_wback;
    logic          w_halt_dec;

    assign w_in_decode = (state == ST_DECODE);
    assign w_in_wback  = (state == ST_WBACK);
    assign w_halt_dec  = w_in_decode && (imem_data[IW-1 -: OPW] == HALT_OP);

    // S is registered so it rises during EXECUTE of a halting instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_state <= RUN_HALTED;
            S           <= 1'b1;
        end else begin
            case (r_run_state)
                RUN_HALTED: begin
                    if (start) begin
                        r_run_state <= RUN_ACTIVE;
                        S           <= 1'b0;
                    end
                end
                RUN_ACTIVE: begin
                    if (w_halt_dec) begin
                        r_run_state <= RUN_HALTED;
                        S           <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_q <= '0;
        end else if (w_in_decode) begin
            r_ir_q <= imem_data;
        end
    end

    // A halt advances the PC at decode so a later start resumes past it.
    fetch_pc #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .inc    ((w_in_wback && !br_taken) || w_halt_dec),
        .load   (w_in_wback && br_taken),
        .target (br_target),
        .pc     (w_pc)
    );

    always_comb begin
        ir       = r_ir_q;
        ir_valid = 1'b0;
        case (state)
            ST_DECODE: begin
                ir       = imem_data;
                ir_valid = 1'b1;
            end
            ST_EXECUTE, ST_WBACK: ir_valid = 1'b1;
            default: ;
        endcase
    end

    assign imem_rd   = (state == ST_FETCH);
    assign imem_addr = w_pc;
    assign pc        = w_pc;

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_in_wback || w_halt_dec) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the cycle sequencer and a
// 1-cycle-latency instruction memory; one line per checked value.
module tb_fetch_unit;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2,
                           EXECUTE = 3'd3, WBACK = 3'd4;

    logic        clk = 1'b0;
    logic        reset, start, br_taken;
    logic [2:0]  state;
    logic [7:0]  br_target;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic        ir_valid;
    logic [7:0]  pc;
    logic        S;
`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] retired;
`endif

    logic [15:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    fetch_unit #(.AW(8), .IW(16), .OPW(4), .HALT_OP(4'hF), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .start     (start),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .S         (S)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .retired   (retired)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One sequencer cycle: drive at negedge, settle, then the caller samples.
    task automatic cyc(input logic [2:0] st, input logic s, input logic b,
                       input logic [7:0] t, input logic r);
        @(negedge clk);
        state = st; start = s; br_taken = b; br_target = t; reset = r;
        #1;
    endtask

    task automatic run_instr(input logic wb_br, input logic [7:0] wb_tgt);
        cyc(FETCH,   1'b0, 1'b0,  8'h00,  1'b0);
        cyc(DECODE,  1'b0, 1'b0,  8'h00,  1'b0);
        cyc(EXECUTE, 1'b0, 1'b0,  8'h00,  1'b0);
        cyc(WBACK,   1'b0, wb_br, wb_tgt, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'h1234; mem[1] = 16'h2000; mem[2] = 16'h3333;
        mem[3] = 16'hF000; mem[4] = 16'h4444; mem[8'h40] = 16'h5555;
        mem[8'hFF] = 16'h6666;
        state = IDLE; start = 1'b0; br_taken = 1'b0; br_target = 8'h00; reset = 1'b1;

        // Reset, with a start request that reset must override
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(IDLE, 1'b1, 1'b0, 8'h00, 1'b1);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_S", 32'(S), 1);
        check("rst_pc", 32'(pc), 0);
        check("rst_ir_valid", 32'(ir_valid), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_imem_rd", 32'(imem_rd), 0);

        cyc(IDLE, 1'b1, 1'b0, 8'h00, 1'b0);
        check("S_at_start", 32'(S), 1);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("S_after_start", 32'(S), 0);

        // Instruction 0: plain, no branch
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check("f0_rd", 32'(imem_rd), 1);
        check("f0_addr", 32'(imem_addr), 32'h00);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("d0_ir", 32'(ir), 32'h1234);
        check("d0_ir_valid", 32'(ir_valid), 1);
        check("d0_rd", 32'(imem_rd), 0);
        cyc(EXECUTE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("e0_ir", 32'(ir), 32'h1234);
        cyc(WBACK, 1'b0, 1'b0, 8'h00, 1'b0);
        check("w0_ir", 32'(ir), 32'h1234);
        check("w0_pc", 32'(pc), 32'h00);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("i0_pc", 32'(pc), 32'h01);
        check("i0_ir_valid", 32'(ir_valid), 0);
        check("i0_ir_held", 32'(ir), 32'h1234);

        // Instruction 1: br_taken pulsed in EXECUTE only must be ignored
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check("f1_addr", 32'(imem_addr), 32'h01);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("d1_ir", 32'(ir), 32'h2000);
        cyc(EXECUTE, 1'b0, 1'b1, 8'h80, 1'b0);
        cyc(WBACK, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("br_exec_only_pc", 32'(pc), 32'h02);

        // Sequencer abandons instruction 2 after DECODE: nothing moves
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("d2a_ir", 32'(ir), 32'h3333);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("abort_pc", 32'(pc), 32'h02);
        cyc(3'd5, 1'b0, 1'b0, 8'h00, 1'b0);
        check("code5_ir_valid", 32'(ir_valid), 0);
        check("code5_pc", 32'(pc), 32'h02);

        // Instruction 2 re-fetched; start while running is ignored
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check("f2_refetch_addr", 32'(imem_addr), 32'h02);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(EXECUTE, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(WBACK, 1'b0, 1'b0, 8'h00, 1'b0);
        check("start_in_run_S", 32'(S), 0);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("i2_pc", 32'(pc), 32'h03);

        // Instruction 3 halts
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("d3_ir", 32'(ir), 32'hF000);
        check("d3_S", 32'(S), 0);
        cyc(EXECUTE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("halt_S", 32'(S), 1);
        check("halt_pc", 32'(pc), 32'h04);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("halt_ir_valid", 32'(ir_valid), 0);
        check("halt_idle_S", 32'(S), 1);
        cyc(IDLE, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("restart_S", 32'(S), 0);

        // Instruction 4 branches to 0x40
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check("f4_addr", 32'(imem_addr), 32'h04);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("d4_ir", 32'(ir), 32'h4444);
        cyc(EXECUTE, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(WBACK, 1'b0, 1'b1, 8'h40, 1'b0);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("br_pc", 32'(pc), 32'h40);
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        check("br_fetch_addr", 32'(imem_addr), 32'h40);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("d40_ir", 32'(ir), 32'h5555);
        cyc(EXECUTE, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(WBACK, 1'b0, 1'b1, 8'hFF, 1'b0);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("br_ff_pc", 32'(pc), 32'hFF);

        // Non-branch at 0xFF wraps to 0
        run_instr(1'b0, 8'h00);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("wrap_pc", 32'(pc), 32'h00);
`ifdef FETCH_INSTR_COUNT_EN
        check("retired_7", retired, 7);
`endif

        // Reset during EXECUTE
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(EXECUTE, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_S", 32'(S), 1);
        check("midrst_ir_valid", 32'(ir_valid), 0);
        check("midrst_ir", 32'(ir), 0);

`ifdef FETCH_INSTR_COUNT_EN
        // Five instructions, the last one halting
        check("retired_rst", retired, 0);
        mem[3] = 16'h3000;
        mem[4] = 16'hF000;
        cyc(IDLE, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(IDLE, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 4; n++) run_instr(1'b0, 8'h00);
        cyc(FETCH, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(DECODE, 1'b0, 1'b0, 8'h00, 1'b0);
        check("cnt_halt_ir", 32'(ir), 32'hF000);
        cyc(EXECUTE, 1'b1, 1'b0, 8'h00, 1'b0);
        check("retired_5", retired, 5);
        check("cnt_halt_S", 32'(S), 1);
        check("cnt_halt_pc", 32'(pc), 32'h05);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
